// File: rtl/ram_responder.sv
// RAM responder: executes the control unit's RAM strobes against a distributed-RAM store
// on the shared bus, clears the array after reset, and holds the CPU off with o_busy.
// Optional mapped output register at IO_BASE is enabled by defining RAM_MMIO_EN.
module ram_responder #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(8'h00),
  parameter logic [ADDR_WIDTH-1:0] IO_BASE     = ADDR_WIDTH'(8'hFE)
) (
  input  logic                  i_clk,
  input  logic                  i_nReset,
  input  logic                  i_ctrlRamAddressEn,
  input  logic                  i_ctrlRamWriteEn,
  input  logic                  i_ctrlRamReadDataSelect,
  input  logic                  i_ctrlRamOE,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_bus,
  output logic [DATA_WIDTH-1:0] o_bus,
  output logic                  o_busDrive,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic                  o_busy
`ifdef RAM_MMIO_EN
  ,
  output logic [DATA_WIDTH-1:0] o_ioData,
  output logic                  o_ioStrobe
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Single state bit: CLEAR encodes as 1 so o_busy is the state flop itself.
  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clear_cnt;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_clear_we;
  logic                  w_run;
  logic                  w_clear_last;
  logic                  w_addr_ld;
  logic                  w_wr_req;
  logic                  w_ram_wr;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_clear_last = &r_clear_cnt;

  // State register
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave CLEAR on the edge that writes the last address
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (w_clear_last) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // State-decoded controls
  always_comb begin
    w_clear_we = 1'b0;
    w_run      = 1'b0;
    case (r_state)
      S_CLEAR: w_clear_we = 1'b1;
      S_RUN:   w_run      = 1'b1;
      default: w_clear_we = 1'b1;
    endcase
  end

  assign w_addr_ld = w_run & i_ctrlRamAddressEn;
  assign w_wr_req  = w_run & i_ctrlRamWriteEn;

  // Clear counter stops on the last address instead of wrapping
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_clear_cnt <= '0;
    end else if (w_clear_we && !w_clear_last) begin
      r_clear_cnt <= r_clear_cnt + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_address <= '0;
    end else if (w_addr_ld) begin
      r_address <= ADDR_WIDTH'(i_bus);
    end
  end

`ifdef RAM_MMIO_EN
  logic                  w_io_hit_wr;
  logic                  w_io_we;
  logic                  w_io_hit_rd;
  logic [DATA_WIDTH-1:0] r_ioData;
  logic                  r_ioStrobe;

  assign w_io_hit_wr = (r_address == IO_BASE);
  assign w_io_we     = w_wr_req & w_io_hit_wr;
  assign w_ram_wr    = w_wr_req & ~w_io_hit_wr;

  // Mapped output register with a one-cycle strobe per write
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_ioData   <= '0;
      r_ioStrobe <= 1'b0;
    end else begin
      r_ioStrobe <= w_io_we;
      if (w_io_we) r_ioData <= i_bus;
    end
  end

  assign o_ioData   = r_ioData;
  assign o_ioStrobe = r_ioStrobe;
`else
  logic w_io_base_unused;

  assign w_ram_wr         = w_wr_req;
  assign w_io_base_unused = ^IO_BASE;
`endif

  // Write port shared by the clear sequence and RUN writes; a write racing reset is dropped
  assign w_mem_we    = (w_clear_we | w_ram_wr) & i_nReset;
  assign w_mem_waddr = w_clear_we ? r_clear_cnt : r_address;
  assign w_mem_wdata = w_clear_we ? CLEAR_VALUE : i_bus;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Asynchronous reads: old data is visible until the write edge
  assign w_rd_addr     = i_ctrlRamReadDataSelect ? i_pc : r_address;
  assign w_rd_data     = r_mem[w_rd_addr];
  assign o_instruction = r_mem[i_pc];

`ifdef RAM_MMIO_EN
  assign w_io_hit_rd = (w_rd_addr == IO_BASE);
  assign o_bus       = w_io_hit_rd ? r_ioData : w_rd_data;
`else
  assign o_bus       = w_rd_data;
`endif

  assign o_busy     = (r_state == S_CLEAR);
  assign o_busDrive = i_ctrlRamOE & ~o_busy;

endmodule
